// File: rtl/lsu_store_buffer.sv
// Load/store unit with a posted store buffer in front of a combinational-read data memory.
// Define LSU_FORWARD_EN for store-to-load forwarding; otherwise loads that hit the buffer stall until drained.
module lsu_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    input  logic          flush,
    output logic          flush_done,
    output logic          empty,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] buf_addr [DEPTH];
    logic [DW-1:0] buf_data [DEPTH];
    logic [PW-1:0] head, tail, idx;
    logic [PW:0]   count, count_nxt;
    logic          hit, load_block, load_acc, store_acc, drain;
    logic          flush_done_nxt;
    logic [DW-1:0] rd_sel;
`ifdef LSU_FORWARD_EN
    logic [DW-1:0] fwd_data;
`endif

    // Walk oldest to youngest so the last match seen is the youngest entry.
    always_comb begin
        hit = 1'b0;
        idx = head;
`ifdef LSU_FORWARD_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (((PW+1)'(k) < count) && (buf_addr[idx] == req_addr)) begin
                hit = 1'b1;
`ifdef LSU_FORWARD_EN
                fwd_data = buf_data[idx];
`endif
            end
        end
    end

`ifdef LSU_FORWARD_EN
    assign load_block = 1'b0;
    assign rd_sel     = hit ? fwd_data : mem_data_out;
`else
    assign load_block = !req_write && hit;
    assign rd_sel     = mem_data_out;
`endif

    // Full stalls loads too, so a full buffer always drains on the next cycle.
    assign req_ready = (state == RUN) && (count != (PW+1)'(DEPTH)) && !load_block;
    assign load_acc  = req_valid && req_ready && !req_write;
    assign store_acc = req_valid && req_ready && req_write;
    assign drain     = (count != '0) && !load_acc;
    assign count_nxt = count + (PW+1)'(store_acc) - (PW+1)'(drain);

    assign empty        = (count == '0);
    assign mem_write_en = drain;
    assign mem_address  = load_acc ? req_addr : buf_addr[head];
    assign mem_data_in  = buf_data[head];

    always_comb begin
        state_nxt      = state;
        flush_done_nxt = 1'b0;
        case (state)
            RUN: begin
                if (flush) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (count_nxt == '0) begin
                    state_nxt      = RUN;
                    flush_done_nxt = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            flush_done <= flush_done_nxt;
            rsp_valid  <= load_acc;
            if (load_acc) rsp_rdata <= rd_sel;
            if (drain) head <= head + 1'b1;
            if (store_acc) tail <= tail + 1'b1;
        end
    end

    // Entry payload needs no reset: count gates every use of it.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            buf_addr[tail] <= req_addr;
            buf_data[tail] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Self-checking bench for lsu_store_buffer: queue-based reference model plus directed literal checks.
module tb_lsu_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_write, flush;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready, rsp_valid, flush_done, empty, mem_write_en;
    logic [DW-1:0] rsp_rdata, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;

    logic [DW-1:0] mem [256];
    assign mem_data_out = mem[mem_address];

    always #5 clk = ~clk;

    lsu_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .flush(flush), .flush_done(flush_done), .empty(empty),
        .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model state
    ent_t          q[$];
    logic [DW-1:0] ref_mem [256];
    bit            m_flush, m_rsp_v, m_fd;
    logic [DW-1:0] m_rsp_d;

    int n_cmp, n_bad;

    // Outputs captured during the most recent step
    logic          c_ready, c_we, c_rv, c_fd, c_empty;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_din, c_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_flush = 0;
        m_rsp_v = 0;
        m_rsp_d = '0;
        m_fd    = 0;
    endtask

    task automatic step(input bit v, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit f);
        bit            match, e_ready, lacc, sacc, drn;
        logic [DW-1:0] yd;
        ent_t          e;
        @(negedge clk);
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; flush = f;
        #1;
        match = 0;
        yd    = '0;
        foreach (q[i]) if (q[i].a == a) begin match = 1; yd = q[i].d; end
        e_ready = !m_flush && (q.size() != DEPTH);
`ifndef LSU_FORWARD_EN
        if (!w && match) e_ready = 0;
`endif
        lacc = v && e_ready && !w;
        sacc = v && e_ready && w;
        drn  = (q.size() != 0) && !lacc;

        c_ready = req_ready; c_we = mem_write_en; c_addr = mem_address; c_din = mem_data_in;
        c_rv = rsp_valid; c_rd = rsp_rdata; c_fd = flush_done; c_empty = empty;

        chk("req_ready", req_ready, e_ready);
        chk("empty", empty, q.size() == 0);
        chk("mem_write_en", mem_write_en, drn);
        if (lacc) chk("mem_address_load", mem_address, a);
        if (drn) begin
            chk("mem_address_drain", mem_address, q[0].a);
            chk("mem_data_in", mem_data_in, q[0].d);
        end
        chk("rsp_valid", rsp_valid, m_rsp_v);
        chk("rsp_rdata", rsp_rdata, m_rsp_d);
        chk("flush_done", flush_done, m_fd);

        @(posedge clk);
        if (c_we) mem[c_addr] = c_din;

        if (lacc) begin
            m_rsp_v = 1;
            m_rsp_d = match ? yd : ref_mem[a];
        end else begin
            m_rsp_v = 0;
        end
        if (drn) begin
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (sacc) begin
            e.a = a;
            e.d = d;
            q.push_back(e);
        end
        m_fd = 0;
        if (!m_flush) begin
            if (f) m_flush = 1;
        end else if (q.size() == 0) begin
            m_flush = 0;
            m_fd    = 1;
        end
    endtask

    task automatic load_wait(input logic [AW-1:0] a);
        int tries = 0;
        do begin
            step(1, 0, a, '0, 0);
            tries++;
        end while (!c_ready && tries < 8);
        chk("load_accept", c_ready, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; flush = 0;
        model_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_mem_write_en", mem_write_en, 0);
        @(negedge clk);
        reset = 0;

        // Single store drains on the following idle cycle
        step(1, 1, 8'h10, 8'h12, 0);
        step(0, 0, 8'h00, 8'h00, 0);
        chk("t1_we", c_we, 1);
        chk("t1_addr", c_addr, 8'h10);
        chk("t1_din", c_din, 8'h12);
        step(0, 0, 8'h00, 8'h00, 0);
        chk("t1_empty", c_empty, 1);

        // Store then immediate load of the same address
        step(1, 1, 8'h20, 8'hAA, 0);
`ifdef LSU_FORWARD_EN
        step(1, 0, 8'h20, 8'h00, 0);
        chk("t2_ready_fwd", c_ready, 1);
`else
        step(1, 0, 8'h20, 8'h00, 0);
        chk("t2_stall", c_ready, 0);
        step(1, 0, 8'h20, 8'h00, 0);
        chk("t2_ready_retry", c_ready, 1);
`endif
        step(0, 0, 8'h00, 8'h00, 0);
        chk("t2_rsp_valid", c_rv, 1);
        chk("t2_rsp_rdata", c_rd, 8'hAA);

        // Two stores to one address: the younger value is returned
        step(1, 1, 8'h30, 8'h01, 0);
        step(1, 1, 8'h30, 8'h02, 0);
        load_wait(8'h30);
        step(0, 0, 8'h00, 8'h00, 0);
        chk("t3_youngest", c_rd, 8'h02);

        // Stores interleaved with loads to one address
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 8'h40, 8'(i + 1), 0);
            load_wait(8'h40);
        end
        step(0, 0, 8'h00, 8'h00, 0);
        chk("t4_last", c_rd, 8'h04);

        // Flush after three stores
        step(1, 1, 8'h50, 8'h31, 0);
        step(1, 1, 8'h51, 8'h32, 0);
        chk("t5_wr0_addr", c_addr, 8'h50);
        chk("t5_wr0_data", c_din, 8'h31);
        step(1, 1, 8'h52, 8'h33, 0);
        chk("t5_wr1_addr", c_addr, 8'h51);
        step(0, 0, 8'h00, 8'h00, 1);
        chk("t5_wr2_addr", c_addr, 8'h52);
        chk("t5_wr2_data", c_din, 8'h33);
        step(1, 1, 8'h53, 8'h44, 1);
        chk("t5_flush_ready", c_ready, 0);
        step(0, 0, 8'h00, 8'h00, 0);
        chk("t5_flush_done", c_fd, 1);
        step(0, 0, 8'h00, 8'h00, 0);
        chk("t5_flush_done_once", c_fd, 0);

        // Asynchronous reset with a store pending and a response in flight
        step(1, 1, 8'h60, 8'h55, 0);
        step(1, 0, 8'h70, 8'h00, 0);
        @(negedge clk);
        req_valid = 0; flush = 0;
        #1;
        chk("t6_pre_rsp_valid", rsp_valid, 1);
        #2;
        reset = 1;
        #1;
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_empty", empty, 1);
        chk("t6_we", mem_write_en, 0);
        chk("t6_ready", req_ready, 1);
        @(negedge clk);
        reset = 0;
        model_reset();
        repeat (3) step(0, 0, 8'h00, 8'h00, 0);
        chk("t6_discard", mem[8'h60], 8'h00);

        // Randomized traffic over a small address window to provoke hits
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 10) < 7, $urandom % 2, 8'h80 + 8'($urandom_range(0, 7)),
                 8'($urandom), ($urandom % 25) == 0);
        end
        repeat (6) step(0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
